// File: rtl/i2c_pkg.sv
// rtl/i2c_pkg.sv - shared states and bus constants for the I2C register target
package i2c_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ACK_ADDR,
        ST_PTR,
        ST_ACK_PTR,
        ST_RX,
        ST_ACK_RX,
        ST_TX,
        ST_MACK,
        ST_WAIT
    } state_t;

    localparam logic I2C_ACK  = 1'b0;
    localparam logic I2C_NACK = 1'b1;
    localparam logic RW_WRITE = 1'b0;
    localparam logic RW_READ  = 1'b1;

endpackage

// File: rtl/i2c_sync_edge.sv
// rtl/i2c_sync_edge.sv - 2-FF pin synchroniser with rise/fall pulses
module i2c_sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic s1, s2, s3;

    // Preset high to match the idle bus so reset release creates no edges
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= 1'b1;
            s2 <= 1'b1;
            s3 <= 1'b1;
        end else begin
            s1 <= din;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign level = s2;
    assign rise  = s2 & ~s3;
    assign fall  = ~s2 & s3;

endmodule

// File: rtl/i2c_slave_regs.sv
// rtl/i2c_slave_regs.sv - I2C target with pointer-addressed byte register file
module i2c_slave_regs
    import i2c_pkg::*;
#(
    parameter logic [6:0] ADDR  = 7'h01,
    parameter int         DEPTH = 16,
    localparam int        AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          scl_in,
    input  logic          sda_in,
    output logic          sda_oe,
    input  logic          host_we,
    input  logic [AW-1:0] host_addr,
    input  logic [7:0]    host_wdata,
    output logic [7:0]    host_rdata,
    output logic          wr_pulse,
    output logic [AW-1:0] wr_index,
    output logic          busy
);

    logic scl_lvl, scl_rise, scl_fall;
    logic sda_lvl, sda_rise, sda_fall;

    i2c_sync_edge u_scl (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (scl_in),
        .level (scl_lvl),
        .rise  (scl_rise),
        .fall  (scl_fall)
    );

    i2c_sync_edge u_sda (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (sda_in),
        .level (sda_lvl),
        .rise  (sda_rise),
        .fall  (sda_fall)
    );

    logic start, stop;
    assign start = sda_fall & scl_lvl;
    assign stop  = sda_rise & scl_lvl;

    state_t        state, state_n;
    logic [3:0]    cnt, cnt_n;
    logic [7:0]    sr, sr_n;
    logic [AW-1:0] ptr, ptr_n;
    logic          oe_n, busy_n;
    logic          commit, load_tx;
    logic [7:0]    rd_byte;
    logic [7:0]    regs [DEPTH];

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        sr_n    = sr;
        ptr_n   = ptr;
        oe_n    = sda_oe;
        busy_n  = busy;
        commit  = 1'b0;
        load_tx = 1'b0;
        rd_byte = regs[ptr];

        if (stop) begin
            state_n = ST_IDLE;
            oe_n    = 1'b0;
            busy_n  = 1'b0;
        end else if (start) begin
            state_n = ST_ADDR;
            cnt_n   = 4'd0;
        end else if (scl_rise) begin
            case (state)
                ST_ADDR, ST_PTR, ST_RX: begin
                    sr_n  = {sr[6:0], sda_lvl};
                    cnt_n = cnt + 4'd1;
                    if (state == ST_RX && cnt == 4'd7) commit = 1'b1;
                end
                ST_TX:   cnt_n = cnt + 4'd1;
                // cnt==1 marks a master ACK so the following fall reloads
                ST_MACK: begin
                    if (sda_lvl == I2C_NACK) state_n = ST_WAIT;
                    else                     cnt_n   = 4'd1;
                end
                default: ;
            endcase
        end else if (scl_fall) begin
            case (state)
                ST_ADDR: begin
                    if (cnt == 4'd8) begin
                        if (sr[7:1] == ADDR) begin
                            state_n = ST_ACK_ADDR;
                            oe_n    = ~I2C_ACK;
                            busy_n  = 1'b1;
                        end else begin
                            state_n = ST_IDLE;
                            busy_n  = 1'b0;
                        end
                    end
                end
                ST_PTR: begin
                    if (cnt == 4'd8) begin
                        ptr_n   = sr[AW-1:0];
                        state_n = ST_ACK_PTR;
                        oe_n    = ~I2C_ACK;
                    end
                end
                ST_RX: begin
                    if (cnt == 4'd8) begin
                        state_n = ST_ACK_RX;
                        oe_n    = ~I2C_ACK;
                    end
                end
                ST_ACK_ADDR: begin
                    if (sr[0] == RW_WRITE) begin
                        state_n = ST_PTR;
                        cnt_n   = 4'd0;
                        oe_n    = 1'b0;
                    end else begin
                        load_tx = 1'b1;
                    end
                end
                ST_ACK_PTR, ST_ACK_RX: begin
                    state_n = ST_RX;
                    cnt_n   = 4'd0;
                    oe_n    = 1'b0;
                end
                ST_TX: begin
                    if (cnt == 4'd8) begin
                        state_n = ST_MACK;
                        cnt_n   = 4'd0;
                        oe_n    = 1'b0;
                    end else begin
                        sr_n = {sr[6:0], 1'b0};
                        oe_n = ~sr[6];
                    end
                end
                ST_MACK: if (cnt == 4'd1) load_tx = 1'b1;
                default: ;
            endcase
        end

        // Bit 7 goes out on the same fall that loads the byte
        if (load_tx) begin
            sr_n    = rd_byte;
            ptr_n   = ptr + 1'b1;
            oe_n    = ~rd_byte[7];
            cnt_n   = 4'd0;
            state_n = ST_TX;
        end
        if (commit) ptr_n = ptr + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            cnt    <= 4'd0;
            sr     <= 8'd0;
            ptr    <= '0;
            sda_oe <= 1'b0;
            busy   <= 1'b0;
        end else begin
            state  <= state_n;
            cnt    <= cnt_n;
            sr     <= sr_n;
            ptr    <= ptr_n;
            sda_oe <= oe_n;
            busy   <= busy_n;
        end
    end

    // An I2C commit to the same index beats a concurrent host write
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) regs[i] <= 8'd0;
            wr_pulse   <= 1'b0;
            wr_index   <= '0;
            host_rdata <= 8'd0;
        end else begin
            wr_pulse   <= commit;
            host_rdata <= regs[host_addr];
            if (host_we && !(commit && host_addr == ptr)) regs[host_addr] <= host_wdata;
            if (commit) begin
                regs[ptr] <= sr_n;
                wr_index  <= ptr;
            end
        end
    end

endmodule
